// File: rtl/wgt_sched_pkg.sv
// Shared definitions for the weight-buffer read scheduler: state encoding and
// the default counter width.
package wgt_sched_pkg;

    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_WAIT_GRP = 3'd2,
        S_READ     = 3'd3,
        S_GAP      = 3'd4,
        S_END      = 3'd5
    } state_e;

endpackage

// File: rtl/wgt_grp_counter.sv
// Nested word/group counter. The word count advances on each pop and wraps on
// the last word of a group. The group index advances on request.
module wgt_grp_counter
    import wgt_sched_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             pop,
    input  logic             grp_adv,
    input  logic [CNT_W-1:0] cfg_words,
    input  logic [CNT_W-1:0] cfg_groups,
    output logic [CNT_W-1:0] grp_idx,
    output logic             last_word,
    output logic             last_grp
);

    logic [CNT_W-1:0] word_cnt_q;
    logic [CNT_W-1:0] grp_idx_q;

    // Both cfg values are nonzero whenever these flags are consulted.
    assign last_word = (word_cnt_q == cfg_words - CNT_W'(1));
    assign last_grp  = (grp_idx_q == cfg_groups - CNT_W'(1));
    assign grp_idx   = grp_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q <= '0;
            grp_idx_q  <= '0;
        end else if (clr) begin
            word_cnt_q <= '0;
            grp_idx_q  <= '0;
        end else begin
            if (pop) begin
                word_cnt_q <= last_word ? '0 : word_cnt_q + CNT_W'(1);
            end
            if (grp_adv) begin
                grp_idx_q <= grp_idx_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/wgt_read_sched.sv
// Weight resize-buffer read scheduler: one op_start, cfg_words x cfg_groups pops
// gated per group by pe_ready, and one closing end_conv.
module wgt_read_sched
    import wgt_sched_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned GRP_GAP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_words,
    input  logic [CNT_W-1:0] cfg_groups,
    input  logic             pe_ready,
    input  logic             g_stall,
    input  logic             buf_stall,
    output logic             op_start,
    output logic             wgt_read,
    output logic             end_conv,
    output logic             wgt_vld,
    output logic             wgt_last,
    output logic [CNT_W-1:0] grp_idx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned GAP_W = (GRP_GAP > 1) ? $clog2(GRP_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GRP_GAP == 0) ? 0 : GRP_GAP - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cfg_words_q, cfg_groups_q;
    logic             aborted_q, aborted_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             vld_q, last_q;
    logic             pop, cnt_clr, grp_adv, last_word, last_grp;

    // The pop request never goes out while the buffer FIFO reports empty.
    assign wgt_read = (state_q == S_READ) && !buf_stall;
    assign pop      = (state_q == S_READ) && !buf_stall && !g_stall;
    assign busy     = (state_q != S_IDLE);
    assign wgt_vld  = vld_q;
    assign wgt_last = last_q;

    wgt_grp_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (cnt_clr),
        .pop        (pop),
        .grp_adv    (grp_adv),
        .cfg_words  (cfg_words_q),
        .cfg_groups (cfg_groups_q),
        .grp_idx    (grp_idx),
        .last_word  (last_word),
        .last_grp   (last_grp)
    );

    always_comb begin
        state_d   = state_q;
        aborted_d = aborted_q;
        gap_cnt_d = gap_cnt_q;
        op_start  = 1'b0;
        end_conv  = 1'b0;
        done      = 1'b0;
        cnt_clr   = 1'b0;
        grp_adv   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_ARM;
                    aborted_d = 1'b0;
                end
            end
            S_ARM: begin
                op_start = 1'b1;
                cnt_clr  = 1'b1;
                if (cfg_words_q == '0 || cfg_groups_q == '0) begin
                    state_d = S_END;
                end else begin
                    state_d = S_WAIT_GRP;
                end
            end
            S_WAIT_GRP: begin
                if (pe_ready) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (pop && last_word) begin
                    if (last_grp) begin
                        state_d = S_END;
                    end else begin
                        grp_adv   = 1'b1;
                        gap_cnt_d = '0;
                        state_d   = (GRP_GAP == 0) ? S_WAIT_GRP : S_GAP;
                    end
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q + GAP_W'(1);
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_WAIT_GRP;
                end
            end
            S_END: begin
                end_conv = 1'b1;
                done     = !aborted_q;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A pop in the abort cycle still completes; only the group advance is dropped.
        if (abort && (state_q inside {S_ARM, S_WAIT_GRP, S_READ, S_GAP})) begin
            state_d   = S_END;
            aborted_d = 1'b1;
            grp_adv   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            aborted_q    <= 1'b0;
            gap_cnt_q    <= '0;
            cfg_words_q  <= '0;
            cfg_groups_q <= '0;
            vld_q        <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            aborted_q <= aborted_d;
            gap_cnt_q <= gap_cnt_d;
            if (state_q == S_IDLE && start) begin
                cfg_words_q  <= cfg_words;
                cfg_groups_q <= cfg_groups;
            end
            // One-cycle FIFO read latency: qualifiers follow the pop by a cycle.
            vld_q  <= pop;
            last_q <= pop && last_word;
        end
    end

endmodule

// File: tb/tb_wgt_read_sched.sv
// Self-checking bench for wgt_read_sched: directed scenarios plus randomized
// layers, checked against a count/sequence model of the scheduler.
module tb_wgt_read_sched;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned GRP_GAP = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] cfg_words = '0;
    logic [CNT_W-1:0] cfg_groups = '0;
    logic             pe_ready = 1'b1;
    logic             g_stall = 1'b0;
    logic             buf_stall = 1'b0;
    logic             op_start, wgt_read, end_conv, wgt_vld, wgt_last, busy, done;
    logic [CNT_W-1:0] grp_idx;

    // Stimulus mode controls, written only by the main sequence.
    bit rand_en = 0, force_gst = 0, force_bst = 0, rdy_low = 0, mon_clr = 0;

    int vectors = 0;
    int errors  = 0;

    wgt_read_sched #(
        .CNT_W   (CNT_W),
        .GRP_GAP (GRP_GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .cfg_words  (cfg_words),
        .cfg_groups (cfg_groups),
        .pe_ready   (pe_ready),
        .g_stall    (g_stall),
        .buf_stall  (buf_stall),
        .op_start   (op_start),
        .wgt_read   (wgt_read),
        .end_conv   (end_conv),
        .wgt_vld    (wgt_vld),
        .wgt_last   (wgt_last),
        .grp_idx    (grp_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Handshake/stall drivers, applied 2 time units after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_en) begin
                g_stall   = force_gst || ($urandom_range(0, 99) < 25);
                buf_stall = force_bst || ($urandom_range(0, 99) < 20);
                pe_ready  = !rdy_low && ($urandom_range(0, 99) < 60);
            end else begin
                g_stall   = force_gst;
                buf_stall = force_bst;
                pe_ready  = !rdy_low;
            end
        end
    end

    // Observation monitor, sampled on the falling edge.
    int cyc = 0;
    int n_pop = 0, n_vld = 0, n_opst = 0, n_endc = 0, n_done = 0;
    int opst_cyc = 0, endc_cyc = 0, start_cyc = 0, ab_cyc = 0;
    int vld_bad = 0, last_bad = 0, rd_bst = 0, rd_nrdy = 0, n_both = 0, done_bad = 0;
    int pop_cyc[$];
    int pop_grp[$];
    bit vld_last[$];
    bit prev_pop = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n || mon_clr) begin
            n_pop <= 0; n_vld <= 0; n_opst <= 0; n_endc <= 0; n_done <= 0;
            vld_bad <= 0; last_bad <= 0; rd_bst <= 0; rd_nrdy <= 0;
            n_both <= 0; done_bad <= 0; prev_pop <= 0;
            pop_cyc.delete(); pop_grp.delete(); vld_last.delete();
        end else begin
            if (wgt_read && !g_stall) begin
                n_pop <= n_pop + 1;
                pop_cyc.push_back(cyc);
                pop_grp.push_back(int'(grp_idx));
            end
            if (wgt_vld) begin
                n_vld <= n_vld + 1;
                vld_last.push_back(wgt_last);
            end
            if (wgt_vld != prev_pop) vld_bad <= vld_bad + 1;
            if (wgt_last && !wgt_vld) last_bad <= last_bad + 1;
            if (wgt_read && buf_stall) rd_bst <= rd_bst + 1;
            if (wgt_read && !pe_ready) rd_nrdy <= rd_nrdy + 1;
            if (op_start && end_conv) n_both <= n_both + 1;
            if (done && !end_conv) done_bad <= done_bad + 1;
            if (op_start) begin n_opst <= n_opst + 1; opst_cyc <= cyc; end
            if (end_conv) begin n_endc <= n_endc + 1; endc_cyc <= cyc; end
            if (done) n_done <= n_done + 1;
            if (start && !busy) start_cyc <= cyc;
            if (abort && busy) ab_cyc <= cyc;
            prev_pop <= wgt_read && !g_stall;
        end
    end

    task automatic clear_mon();
        @(posedge clk); #1;
        mon_clr = 1;
        @(posedge clk); #1;
        mon_clr = 0;
    endtask

    // Config is scrambled right after the start pulse; the DUT must ignore it.
    task automatic do_start(input int w, input int g);
        @(posedge clk); #1;
        cfg_words  = CNT_W'(w);
        cfg_groups = CNT_W'(g);
        start      = 1;
        @(posedge clk); #1;
        start      = 0;
        cfg_words  = CNT_W'($urandom);
        cfg_groups = CNT_W'($urandom);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (!busy) begin ok = 1; break; end
        end
    endtask

    task automatic wait_pops(input int n, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (n_pop >= n) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        logic [CNT_W+6:0] outs;
        repeat (3) @(posedge clk);
        #1;
        outs = {op_start, wgt_read, end_conv, wgt_vld, wgt_last, busy, done, grp_idx};
        vectors++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", outs);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_basic();
        bit ok;
        clear_mon();
        do_start(4, 2);
        wait_idle(200, ok);
        vectors++;
        if (ok !== 1'b1) begin errors++; $display("FAIL basic_timeout: busy still high"); end
        vectors++;
        if (n_pop !== 8) begin errors++; $display("FAIL basic_pops: got %0d required 8", n_pop); end
        vectors++;
        if (n_opst !== 1 || opst_cyc !== start_cyc + 1) begin
            errors++;
            $display("FAIL basic_op_start: count %0d at %0d required 1 at %0d",
                     n_opst, opst_cyc, start_cyc + 1);
        end
        for (int i = 0; i < vld_last.size(); i++) begin
            vectors++;
            if (vld_last[i] !== ((i % 4) == 3)) begin
                errors++;
                $display("FAIL basic_last[%0d]: got %0d required %0d", i, vld_last[i], (i % 4) == 3);
            end
        end
        vectors++;
        if (n_endc !== 1 || n_done !== 1 || done_bad !== 0) begin
            errors++;
            $display("FAIL basic_end: end_conv %0d done %0d orphan %0d required 1 1 0",
                     n_endc, n_done, done_bad);
        end
        vectors++;
        if (pop_cyc.size() != 8 || endc_cyc !== pop_cyc[pop_cyc.size() - 1] + 1) begin
            errors++;
            $display("FAIL basic_end_timing: end_conv at %0d, pops %0d", endc_cyc, pop_cyc.size());
        end
        vectors++;
        if (vld_bad !== 0 || n_vld !== 8) begin
            errors++;
            $display("FAIL basic_vld: skew %0d count %0d required 0 8", vld_bad, n_vld);
        end
    endtask

    task automatic test_stall();
        bit ok;
        clear_mon();
        do_start(3, 1);
        wait_pops(1, 100, ok);
        force_gst = 1;
        repeat (2) begin @(posedge clk); #1; end
        force_gst = 0;
        force_bst = 1;
        repeat (3) begin @(posedge clk); #1; end
        force_bst = 0;
        wait_idle(100, ok);
        vectors++;
        if (ok !== 1'b1) begin errors++; $display("FAIL stall_timeout: busy still high"); end
        vectors++;
        if (n_pop !== 3) begin errors++; $display("FAIL stall_pops: got %0d required 3", n_pop); end
        vectors++;
        if (n_vld !== 3) begin errors++; $display("FAIL stall_vld: got %0d required 3", n_vld); end
        vectors++;
        if (rd_bst !== 0) begin
            errors++;
            $display("FAIL stall_read_on_empty: got %0d required 0", rd_bst);
        end
        vectors++;
        if (vld_bad !== 0 || last_bad !== 0) begin
            errors++;
            $display("FAIL stall_vld_timing: skew %0d last %0d required 0 0", vld_bad, last_bad);
        end
    endtask

    task automatic test_group();
        bit ok;
        clear_mon();
        do_start(2, 3);
        wait_pops(2, 100, ok);
        rdy_low = 1;
        repeat (5) begin @(posedge clk); #1; end
        rdy_low = 0;
        wait_idle(200, ok);
        vectors++;
        if (ok !== 1'b1 || n_pop !== 6) begin
            errors++;
            $display("FAIL group_pops: got %0d required 6 (idle %0d)", n_pop, ok);
        end
        vectors++;
        if (rd_nrdy !== 0) begin
            errors++;
            $display("FAIL group_read_unready: got %0d required 0", rd_nrdy);
        end
        for (int i = 0; i < pop_grp.size(); i++) begin
            vectors++;
            if (pop_grp[i] !== i / 2) begin
                errors++;
                $display("FAIL group_idx[%0d]: got %0d required %0d", i, pop_grp[i], i / 2);
            end
        end
        // Group 1: pe_ready low for 5 cycles past the last pop, then one WAIT_GRP cycle.
        // Group 2: GRP_GAP cycles of GAP plus one WAIT_GRP cycle.
        if (pop_cyc.size() == 6) begin
            vectors++;
            if (pop_cyc[2] - pop_cyc[1] !== 7) begin
                errors++;
                $display("FAIL group_gated_gap: got %0d required 7", pop_cyc[2] - pop_cyc[1]);
            end
            vectors++;
            if (pop_cyc[4] - pop_cyc[3] !== GRP_GAP + 2) begin
                errors++;
                $display("FAIL group_idle_gap: got %0d required %0d",
                         pop_cyc[4] - pop_cyc[3], GRP_GAP + 2);
            end
        end
    endtask

    task automatic test_abort();
        bit ok;
        clear_mon();
        do_start(10, 2);
        wait_pops(5, 100, ok);
        abort     = 1;
        force_gst = 1;
        @(posedge clk); #1;
        abort     = 0;
        force_gst = 0;
        wait_idle(50, ok);
        vectors++;
        if (ok !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: busy %0d required 0", busy);
        end
        vectors++;
        if (n_pop !== 5 || n_vld !== 5) begin
            errors++;
            $display("FAIL abort_pops: pops %0d vld %0d required 5 5", n_pop, n_vld);
        end
        vectors++;
        if (n_endc !== 1 || endc_cyc !== ab_cyc + 1) begin
            errors++;
            $display("FAIL abort_end_conv: count %0d at %0d required 1 at %0d",
                     n_endc, endc_cyc, ab_cyc + 1);
        end
        vectors++;
        if (n_done !== 0) begin errors++; $display("FAIL abort_done: got %0d required 0", n_done); end
        clear_mon();
        do_start(3, 2);
        wait_idle(200, ok);
        vectors++;
        if (ok !== 1'b1 || n_pop !== 6 || n_done !== 1) begin
            errors++;
            $display("FAIL abort_restart: pops %0d done %0d required 6 1", n_pop, n_done);
        end
    endtask

    task automatic test_zero();
        bit ok;
        clear_mon();
        do_start(0, 5);
        wait_idle(50, ok);
        vectors++;
        if (ok !== 1'b1 || n_opst !== 1 || endc_cyc !== opst_cyc + 1) begin
            errors++;
            $display("FAIL zero_seq: op_start %0d at %0d end_conv at %0d", n_opst, opst_cyc, endc_cyc);
        end
        vectors++;
        if (n_done !== 1 || n_endc !== 1 || n_both !== 0) begin
            errors++;
            $display("FAIL zero_done: done %0d end_conv %0d overlap %0d required 1 1 0",
                     n_done, n_endc, n_both);
        end
        vectors++;
        if (n_pop !== 0) begin errors++; $display("FAIL zero_pops: got %0d required 0", n_pop); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [CNT_W+6:0] outs;
        clear_mon();
        do_start(8, 1);
        wait_pops(2, 100, ok);
        rst_n = 0;
        #1;
        outs = {op_start, wgt_read, end_conv, wgt_vld, wgt_last, busy, done, grp_idx};
        vectors++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h required 0", outs);
        end
        @(negedge clk);
        rst_n = 1;
        clear_mon();
        do_start(1, 1);
        wait_idle(50, ok);
        vectors++;
        if (ok !== 1'b1 || n_pop !== 1 || n_done !== 1 || n_endc !== 1) begin
            errors++;
            $display("FAIL reset_mid_rerun: pops %0d done %0d end_conv %0d required 1 1 1",
                     n_pop, n_done, n_endc);
        end
    endtask

    task automatic test_random();
        int  w, g, tot;
        bit  ok;
        rand_en = 1;
        for (int l = 0; l < 6; l++) begin
            w   = $urandom_range(1, 6);
            g   = $urandom_range(1, 4);
            tot = w * g;
            clear_mon();
            do_start(w, g);
            ok = 0;
            for (int c = 0; c < 2000; c++) begin
                @(posedge clk); #1;
                start = 0;
                if (!busy) begin ok = 1; break; end
                // Start pulses while pops remain land in a busy state and must be ignored.
                start     = (n_pop < tot) && ($urandom_range(0, 9) == 0);
                cfg_words = CNT_W'($urandom);
            end
            start = 0;
            vectors++;
            if (ok !== 1'b1 || n_pop !== tot || n_vld !== tot) begin
                errors++;
                $display("FAIL rand%0d_pops: pops %0d vld %0d required %0d (%0dx%0d)",
                         l, n_pop, n_vld, tot, w, g);
            end
            for (int i = 0; i < pop_grp.size(); i++) begin
                vectors++;
                if (pop_grp[i] !== i / w) begin
                    errors++;
                    $display("FAIL rand%0d_grp[%0d]: got %0d required %0d", l, i, pop_grp[i], i / w);
                end
            end
            for (int i = 0; i < vld_last.size(); i++) begin
                vectors++;
                if (vld_last[i] !== ((i % w) == w - 1)) begin
                    errors++;
                    $display("FAIL rand%0d_last[%0d]: got %0d required %0d",
                             l, i, vld_last[i], (i % w) == w - 1);
                end
            end
            for (int i = w; i < pop_cyc.size(); i += w) begin
                vectors++;
                if (pop_cyc[i] - pop_cyc[i - 1] < GRP_GAP + 2) begin
                    errors++;
                    $display("FAIL rand%0d_gap[%0d]: got %0d required >= %0d",
                             l, i, pop_cyc[i] - pop_cyc[i - 1], GRP_GAP + 2);
                end
            end
            vectors++;
            if (vld_bad !== 0 || rd_bst !== 0 || last_bad !== 0) begin
                errors++;
                $display("FAIL rand%0d_handshake: skew %0d read_on_empty %0d last %0d required 0",
                         l, vld_bad, rd_bst, last_bad);
            end
            vectors++;
            if (n_opst !== 1 || n_endc !== 1 || n_done !== 1 || n_both !== 0) begin
                errors++;
                $display("FAIL rand%0d_pulses: op %0d end %0d done %0d overlap %0d",
                         l, n_opst, n_endc, n_done, n_both);
            end
        end
        rand_en = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_group();
        test_abort();
        test_zero();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
